// File: rtl/palette_sched_pkg.sv
// Shared types for the palette write scheduler: queued entry layout, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package palette_sched_pkg;

  localparam int PAL_ADDR_W = 11;
  localparam int PAL_DATA_W = 16;

  // Field order gives address = {layer, color, rgb} in the top 11 bits.
  typedef struct packed {
    logic [4:0]            layer;
    logic [4:0]            color;
    logic                  rgb;
    logic [PAL_DATA_W-1:0] data;
  } pal_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  function automatic logic [PAL_ADDR_W-1:0] entry_addr(input pal_entry_t e);
    return {e.layer, e.color, e.rgb};
  endfunction

endpackage

// File: rtl/palette_write_fifo.sv
// Circular queue of palette entries with head read and tail peek/overwrite.
// Latency: push visible at head one cycle after the push edge; count updates on the push/pop edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
// Ports: push/push_dat enqueue; pop dequeues head_dat; tail_wr/tail_wr_dat rewrite data of
//        the newest entry (tail_dat peeks it); count/full/empty report occupancy.
module palette_write_fifo
  import palette_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  pal_entry_t             push_dat,
  input  logic                   pop,
  output pal_entry_t             head_dat,
  input  logic                   tail_wr,
  input  logic [PAL_DATA_W-1:0]  tail_wr_dat,
  output pal_entry_t             tail_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  pal_entry_t    mem_q [DEPTH];
  pal_entry_t    mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx, rd_idx, tail_idx;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign tail_idx = wr_idx - AW'(1);

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (MSBs equal).
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign head_dat = mem_q[rd_idx];
  assign tail_dat = mem_q[tail_idx];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_idx] = push_dat;
      wr_ptr_d      = wr_ptr_q + (AW+1)'(1);
    end
    if (tail_wr && !empty) begin
      mem_d[tail_idx].data = tail_wr_dat;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/palette_write_scheduler.sv
// Queues host palette writes and commits them only in vblank with pipe idle, or on flush.
// Latency: accept at edge A -> WAIT at A+1, first pop at A+2 (palWriteEn high A+2..A+3) if window open.
// Backpressure: hostWriteReady = !full (plus coalescible writes when PALETTE_SCHED_COALESCE_EN).
// Ports: host* request side; vblank/pipeBusy/flushReq open the commit window; pal* registered
//        palette write port; pending = queue occupancy; commitDone pulses when a commit drains.
// Build option: define PALETTE_SCHED_COALESCE_EN to merge writes hitting the tail entry's address.
module palette_write_scheduler
  import palette_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_pipe,
  input  logic                   rst,
  input  logic                   hostWriteValid,
  output logic                   hostWriteReady,
  input  logic [4:0]             hostLayer,
  input  logic [4:0]             hostColor,
  input  logic                   hostRGB,
  input  logic [15:0]            hostWriteData,
  input  logic                   vblank,
  input  logic                   pipeBusy,
  input  logic                   flushReq,
  output logic                   palWriteEn,
  output logic [4:0]             palLayer,
  output logic [4:0]             palColor,
  output logic                   palRGB,
  output logic [15:0]            palWriteData,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   commitDone
);

  localparam int CW = $clog2(DEPTH) + 1;

  pal_entry_t   host_ent, head_ent, tail_ent;
  logic         fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt, cnt_next;
  logic         window, pop, push, accept, coalesce_hit, tail_wr;
  sched_state_t state_q, state_d;
  logic         flush_latched_q, flush_latched_d;
  logic         pal_we_q, pal_we_d;
  pal_entry_t   pal_q, pal_d;

  assign host_ent = {hostLayer, hostColor, hostRGB, hostWriteData};
  assign window   = (vblank && !pipeBusy) || flush_latched_q;

`ifdef PALETTE_SCHED_COALESCE_EN
  // Merging into an entry that leaves the queue on this same edge would lose the write.
  assign coalesce_hit   = !fifo_empty
                          && (entry_addr(tail_ent) == entry_addr(host_ent))
                          && !(pop && (fifo_cnt == CW'(1)));
  assign hostWriteReady = !fifo_full || coalesce_hit;
`else
  logic [$bits(pal_entry_t)-1:0] unused_tail;
  assign unused_tail    = tail_ent;
  assign coalesce_hit   = 1'b0;
  assign hostWriteReady = !fifo_full;
`endif

  assign accept   = hostWriteValid && hostWriteReady;
  assign push     = accept && !coalesce_hit;
  assign tail_wr  = accept && coalesce_hit;
  assign cnt_next = fifo_cnt + CW'(push) - CW'(pop);

  palette_write_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk_pipe),
    .rst_n      (rst),
    .push       (push),
    .push_dat   (host_ent),
    .pop        (pop),
    .head_dat   (head_ent),
    .tail_wr    (tail_wr),
    .tail_wr_dat(hostWriteData),
    .tail_dat   (tail_ent),
    .count      (fifo_cnt),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // FSM: state register.
  always_ff @(posedge clk_pipe or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // A flush with nothing queued completes straight away.
        if ((flushReq || flush_latched_q) && fifo_empty && !push) state_d = DONE;
        else if (!fifo_empty || flush_latched_q)                  state_d = WAIT;
      end
      WAIT: begin
        if (window) state_d = COMMIT;
      end
      COMMIT: begin
        if (cnt_next == '0) state_d = DONE;
        else if (!window)   state_d = WAIT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. The WAIT->COMMIT edge already pops, giving the A+2 first write.
  always_comb begin
    pop        = 1'b0;
    commitDone = 1'b0;
    if ((state_q == WAIT || state_q == COMMIT) && window && !fifo_empty) pop = 1'b1;
    if (state_q == DONE) commitDone = 1'b1;
  end

  // A flush pulse arriving during DONE starts a fresh flush rather than being lost.
  always_comb begin
    flush_latched_d = flush_latched_q;
    if (flushReq)              flush_latched_d = 1'b1;
    else if (state_q == DONE)  flush_latched_d = 1'b0;
  end

  always_comb begin
    pal_we_d = pop;
    pal_d    = pop ? head_ent : pal_q;
  end

  always_ff @(posedge clk_pipe or negedge rst) begin
    if (!rst) begin
      flush_latched_q <= 1'b0;
      pal_we_q        <= 1'b0;
      pal_q           <= '0;
    end else begin
      flush_latched_q <= flush_latched_d;
      pal_we_q        <= pal_we_d;
      pal_q           <= pal_d;
    end
  end

  assign palWriteEn   = pal_we_q;
  assign palLayer     = pal_q.layer;
  assign palColor     = pal_q.color;
  assign palRGB       = pal_q.rgb;
  assign palWriteData = pal_q.data;
  assign pending      = fifo_cnt;

endmodule

// File: tb/tb_palette_write_scheduler.sv
module tb_palette_write_scheduler;
  import palette_sched_pkg::*;

`ifdef PALETTE_SCHED_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk_pipe = 1'b0;
  logic        rst = 1'b0;
  logic        hostWriteValid = 1'b0;
  logic        hostWriteReady;
  logic [4:0]  hostLayer = '0;
  logic [4:0]  hostColor = '0;
  logic        hostRGB = 1'b0;
  logic [15:0] hostWriteData = '0;
  logic        vblank = 1'b0;
  logic        pipeBusy = 1'b0;
  logic        flushReq = 1'b0;
  logic        palWriteEn;
  logic [4:0]  palLayer;
  logic [4:0]  palColor;
  logic        palRGB;
  logic [15:0] palWriteData;
  logic [3:0]  pending;
  logic        commitDone;

  palette_write_scheduler #(.DEPTH(8)) dut (
    .clk_pipe(clk_pipe), .rst(rst),
    .hostWriteValid(hostWriteValid), .hostWriteReady(hostWriteReady),
    .hostLayer(hostLayer), .hostColor(hostColor), .hostRGB(hostRGB),
    .hostWriteData(hostWriteData), .vblank(vblank), .pipeBusy(pipeBusy),
    .flushReq(flushReq), .palWriteEn(palWriteEn), .palLayer(palLayer),
    .palColor(palColor), .palRGB(palRGB), .palWriteData(palWriteData),
    .pending(pending), .commitDone(commitDone)
  );

  always #5 clk_pipe = ~clk_pipe;

  int n_total = 0;
  int n_pass  = 0;
  int n_writes = 0;
  int n_done = 0;
  int wr_run = 0;
  logic prev_we = 1'b0;
  logic [26:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: every palette write is popped from the scoreboard and compared.
  always @(negedge clk_pipe) begin
    logic [26:0] exp_e;
    if (palWriteEn) begin
      n_writes++;
      wr_run = prev_we ? wr_run + 1 : 1;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got 0x%0h with empty scoreboard",
                 {palLayer, palColor, palRGB, palWriteData});
      end else begin
        exp_e = sb.pop_front();
        chk("pal_write", {5'b0, palLayer, palColor, palRGB, palWriteData}, {5'b0, exp_e});
      end
    end
    prev_we = palWriteEn;
    if (commitDone) n_done++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pipe);
    #1;
  endtask

  task automatic push_w(input logic [4:0] l, input logic [4:0] c, input logic r,
                        input logic [15:0] d, input bit coal);
    int k;
    hostLayer = l; hostColor = c; hostRGB = r; hostWriteData = d;
    hostWriteValid = 1'b1;
    #1;
    k = 0;
    while (!hostWriteReady && k < 50) begin
      tick(1);
      k++;
    end
    if (!hostWriteReady) begin
      n_total++;
      $display("FAIL push_timeout: ready stayed 0 for entry 0x%0h", {l, c, r, d});
      hostWriteValid = 1'b0;
    end else begin
      @(posedge clk_pipe);
      #1;
      hostWriteValid = 1'b0;
      if (coal) sb[sb.size()-1] = {l, c, r, d};
      else      sb.push_back({l, c, r, d});
    end
  endtask

  task automatic wait_done(input string nm);
    int base;
    int k;
    base = n_done;
    k = 0;
    while (n_done == base && k < 60) begin
      @(negedge clk_pipe);
      k++;
    end
    if (n_done == base) begin
      n_total++;
      $display("FAIL %s: no commitDone within 60 cycles", nm);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    // Reset values
    tick(2);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_we", 32'(palWriteEn), 0);
    chk("rst_done", 32'(commitDone), 0);
    chk("rst_ready", 32'(hostWriteReady), 1);
    chk("rst_pal", {5'b0, palLayer, palColor, palRGB, palWriteData}, 0);
    rst = 1'b1;
    tick(2);

    // Three writes with window closed, then vblank drains them in order
    w0 = n_writes;
    push_w(5'd1, 5'd2, 1'b0, 16'h1234, 1'b0);
    push_w(5'd2, 5'd3, 1'b1, 16'hBEEF, 1'b0);
    push_w(5'd31, 5'd31, 1'b1, 16'hFFFF, 1'b0);
    chk("t1_pending3", 32'(pending), 3);
    tick(5);
    chk("t1_no_write", 32'(n_writes - w0), 0);
    chk("t1_we_low", 32'(palWriteEn), 0);
    vblank = 1'b1;
    wait_done("t1_done");
    chk("t1_writes", 32'(n_writes - w0), 3);
    chk("t1_consecutive", 32'(wr_run), 3);
    chk("t1_pending0", 32'(pending), 0);
    tick(2);

    // Latency with the window already open
    push_w(5'd4, 5'd5, 1'b0, 16'h0A0A, 1'b0);
    chk("lat_a0", 32'(palWriteEn), 0);
    tick(1);
    chk("lat_a1", 32'(palWriteEn), 0);
    tick(1);
    chk("lat_a2_we", 32'(palWriteEn), 1);
    chk("lat_a2_data", 32'(palWriteData), 32'h0A0A);
    wait_done("lat_done");
    vblank = 1'b0;
    tick(2);

    // Full queue: ready drops after 8, one pop admits the 9th on the next edge
    for (int i = 0; i < 8; i++) push_w(5'(i), 5'(i), 1'b0, 16'(16'h0100 + i), 1'b0);
    chk("full_ready", 32'(hostWriteReady), 0);
    chk("full_pending", 32'(pending), 8);
    hostLayer = 5'd8; hostColor = 5'd8; hostRGB = 1'b0; hostWriteData = 16'h0108;
    hostWriteValid = 1'b1;
    tick(3);
    chk("full_held", 32'(hostWriteReady), 0);
    chk("full_held_pending", 32'(pending), 8);
    vblank = 1'b1;
    tick(1);
    vblank = 1'b0;
    #1;
    chk("full_slot_free", 32'(hostWriteReady), 1);
    @(posedge clk_pipe);
    #1;
    hostWriteValid = 1'b0;
    sb.push_back({5'd8, 5'd8, 1'b0, 16'h0108});
    chk("full_9th_in", 32'(pending), 8);
    vblank = 1'b1;
    wait_done("full_drain");
    chk("full_drained", 32'(pending), 0);
    vblank = 1'b0;
    tick(2);

    // Window closes after two commits, then resumes
    for (int i = 0; i < 5; i++) push_w(5'(10 + i), 5'(i), 1'b1, 16'(16'h2000 + i), 1'b0);
    w0 = n_writes;
    vblank = 1'b1;
    tick(2);
    pipeBusy = 1'b1;
    tick(1);
    chk("busy_we_low", 32'(palWriteEn), 0);
    chk("busy_writes2", 32'(n_writes - w0), 2);
    chk("busy_pending3", 32'(pending), 3);
    chk("busy_state", 32'(dut.state_q), 32'(WAIT));
    tick(3);
    chk("busy_still2", 32'(n_writes - w0), 2);
    pipeBusy = 1'b0;
    wait_done("busy_done");
    chk("busy_writes5", 32'(n_writes - w0), 5);
    vblank = 1'b0;
    tick(2);

    // Flush with window closed
    pipeBusy = 1'b1;
    w0 = n_writes;
    push_w(5'd20, 5'd1, 1'b0, 16'hC001, 1'b0);
    push_w(5'd21, 5'd2, 1'b1, 16'hC002, 1'b0);
    tick(3);
    chk("flush_none_yet", 32'(n_writes - w0), 0);
    flushReq = 1'b1;
    tick(1);
    flushReq = 1'b0;
    wait_done("flush_done");
    chk("flush_writes", 32'(n_writes - w0), 2);
    chk("flush_pending", 32'(pending), 0);
    tick(1);
    chk("flush_cleared", 32'(dut.flush_latched_q), 0);
    // Flush with empty queue: commitDone the cycle after the pulse
    flushReq = 1'b1;
    tick(1);
    flushReq = 1'b0;
    chk("flush_empty_done", 32'(commitDone), 1);
    tick(1);
    chk("flush_empty_pulse", 32'(commitDone), 0);
    chk("flush_empty_clr", 32'(dut.flush_latched_q), 0);
    pipeBusy = 1'b0;
    tick(2);

    // Same-address writes: merged only with coalescing built in
    w0 = n_writes;
    push_w(5'd3, 5'd4, 1'b1, 16'hAAAA, 1'b0);
    push_w(5'd3, 5'd4, 1'b1, 16'h5555, COAL);
    chk("coal_pending", 32'(pending), COAL ? 1 : 2);
    vblank = 1'b1;
    wait_done("coal_done");
    chk("coal_writes", 32'(n_writes - w0), COAL ? 1 : 2);
    vblank = 1'b0;
    tick(2);

    // Reset in the middle of a commit
    for (int i = 0; i < 4; i++) push_w(5'(24 + i), 5'(i), 1'b0, 16'(16'h4000 + i), 1'b0);
    vblank = 1'b1;
    tick(2);
    chk("mid_we", 32'(palWriteEn), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(palWriteEn), 0);
    chk("mid_rst_pending", 32'(pending), 0);
    chk("mid_rst_ready", 32'(hostWriteReady), 1);
    chk("mid_rst_done", 32'(commitDone), 0);
    chk("mid_rst_data", 32'(palWriteData), 0);
    sb.delete();
    w0 = n_writes;
    tick(2);
    rst = 1'b1;
    tick(6);
    chk("post_rst_writes", 32'(n_writes - w0), 0);
    chk("post_rst_pending", 32'(pending), 0);
    vblank = 1'b0;
    tick(2);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/palette_write_scheduler.md
# palette_write_scheduler

Queues host (controller) palette writes and commits them to the palette memory's controller write port only while a safe window is open: vertical blanking with the render pipeline idle, or an explicit flush. This prevents mid-frame palette tearing. The block sits between the host register interface and the palette memory controller, and runs on the pipeline clock that also clocks palette writes. It owns the palette memory write port exclusively.

## Interface
Parameters:
- DEPTH, 8, queue entries; power of two, 2..32.

Ports:
- clk_pipe  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- hostWriteValid  in  1  host write request.
- hostWriteReady  out  1  queue can accept; equals !full.
- hostLayer  in  5  target layer.
- hostColor  in  5  target color slot.
- hostRGB  in  1  half-word select within the slot.
- hostWriteData  in  16  write data.
- vblank  in  1  vertical blanking; already synchronous to clk_pipe.
- pipeBusy  in  1  render pipeline is reading the palette.
- flushReq  in  1  single-cycle pulse that forces a commit.
- palWriteEn  out  1  palette memory write enable; registered.
- palLayer  out  5  registered.
- palColor  out  5  registered.
- palRGB  out  1  registered.
- palWriteData  out  16  registered.
- pending  out  clog2(DEPTH)+1  entries currently queued.
- commitDone  out  1  one-cycle pulse when the queue drains during COMMIT.

## Operation
- Entry = {layer, color, rgb, data}, 27 bits. The 11-bit address is {layer, color, rgb}.
- Accept: a write is accepted on any rising edge where hostWriteValid && hostWriteReady. The entry is pushed at the tail.
- window = (vblank && !pipeBusy) || flushLatched.
- flushLatched is set by flushReq and cleared in the cycle commitDone pulses. A flushReq with an empty queue while in IDLE still produces commitDone one cycle later.
- FSM states:
  - IDLE: queue empty and no flush. Go to WAIT when pending>0 or flushLatched.
  - WAIT: go to COMMIT when window is open.
  - COMMIT: pop the head every cycle. If pending becomes 0, go to DONE. If the window closes, go to WAIT; remaining entries are kept.
  - DONE: pulse commitDone, go to IDLE.
- Writes accepted during COMMIT are committed in the same window.
- Simultaneous push and pop: both occur; pending is unchanged.
- Full queue: hostWriteReady=0. A push is not accepted that cycle even if a pop occurs.
- Entries commit in exact acceptance order.
- Reset mid-COMMIT discards all queued entries. No partial write is issued after reset releases.

## Timing
- Reset values: palWriteEn=0, pal* fields=0, pending=0, commitDone=0, hostWriteReady=1, state=IDLE.
- A pop at edge E loads the pal* registers. palWriteEn is high for the cycle E..E+1, so the palette memory captures the write at edge E+1.
- Latency from acceptance edge A with the window already open:
  - FSM enters WAIT at A+1 and COMMIT at A+2.
  - First pop occurs at A+2; palWriteEn is high during A+2..A+3.
- Throughput: one write per cycle in COMMIT.
- Window close: window is sampled each edge. When it falls, no pop occurs at that edge, and palWriteEn is 0 in the following cycle.
- pending updates on the same edge as the push or pop.

## Configuration
- PALETTE_SCHED_COALESCE_EN defined:
  - A host write whose address equals the tail entry's address overwrites that entry's data instead of pushing, provided pending>0 and that entry is not being popped on the same edge.
  - pending is unchanged.
  - A coalescible write is accepted even when full.
- Undefined: every accepted write pushes a new entry, and ready is strictly !full.

## Structure
- palette_sched_pkg contains:
  - typedef pal_entry_t {layer, color, rgb, data}.
  - state enum {IDLE, WAIT, COMMIT, DONE}.
  - constants PAL_ADDR_W=11 and PAL_DATA_W=16.
- One sub-module, palette_write_fifo:
  - Circular buffer with DEPTH entries, pointers one bit wider than clog2(DEPTH) for full/empty detection, and a tail-peek port used for coalescing.

## Test plan
- Reset, push 3 writes (L1/C2/R0=0x1234, …) with vblank=0 → pending=3, palWriteEn stays 0. Raise vblank → 3 consecutive palWriteEn cycles in order, then commitDone pulse, pending=0.
- DEPTH=8: push 9 writes with no window → hostWriteReady=0 after the 8th, 9th write held off. One pop frees a slot, and the 9th write is accepted that cycle+1.
- Commit in progress with 5 queued; pipeBusy rises after 2 commits → exactly 2 writes, state WAIT, pending=3. pipeBusy falls → remaining 3 commit.
- flushReq with vblank=0, pipeBusy=1, 2 queued → both committed, commitDone, flushLatched cleared.
- COALESCE_EN: push L3/C4/R1=0xAAAA then same address=0x5555 → pending=1, single commit of 0x5555. Without the macro → pending=2, two commits in order.
- Assert rst mid-COMMIT with 4 queued → all outputs at reset values immediately. After release, pending=0 and no palWriteEn.
